// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared encodings, FSM state and size helpers for mem_ctrl
package mem_ctrl_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_e;

  function automatic logic [2:0] size_to_n(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a_lo);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return a_lo[0];
      default: return a_lo != 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_byte_asm.sv
// rtl/mem_ctrl_byte_asm.sv - read byte-lane capture, little-endian assembly and sign/zero extension
module mem_ctrl_byte_asm (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        clr_in,
  input  logic        cap_en_in,
  input  logic [1:0]  cap_idx_in,
  input  logic [7:0]  cap_byte_in,
  input  logic [2:0]  n_bytes_in,
  input  logic        sext_in,
  output logic [31:0] word_out
);

  logic [31:0] lanes_q, lanes_d;

  always_comb begin
    lanes_d = lanes_q;
    if (clr_in) begin
      lanes_d = '0;
    end else if (cap_en_in) begin
      case (cap_idx_in)
        2'd0:    lanes_d[7:0]   = cap_byte_in;
        2'd1:    lanes_d[15:8]  = cap_byte_in;
        2'd2:    lanes_d[23:16] = cap_byte_in;
        default: lanes_d[31:24] = cap_byte_in;
      endcase
    end
  end

  // Built from lanes_d so the byte captured on the final edge lands in the result.
  always_comb begin
    case (n_bytes_in)
      3'd1:    word_out = {{24{sext_in & lanes_d[7]}}, lanes_d[7:0]};
      3'd2:    word_out = {{16{sext_in & lanes_d[15]}}, lanes_d[15:0]};
      default: word_out = lanes_d;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      lanes_q <= '0;
    end else begin
      lanes_q <= lanes_d;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - fetch/data port arbiter serialising 1/2/4-byte accesses onto a byte-wide RAM
// Optional alignment check enabled by MEM_CTRL_ALIGN_CHK_EN.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  if_valid_in,
  input  logic [ADDR_WIDTH-1:0] if_addr_in,
  output logic                  if_ready_out,
  output logic                  if_done_out,
  output logic [31:0]           if_data_out,
  input  logic                  d_valid_in,
  input  logic                  d_we_in,
  input  logic [1:0]            d_size_in,
  input  logic                  d_sext_in,
  input  logic [ADDR_WIDTH-1:0] d_addr_in,
  input  logic [31:0]           d_wdata_in,
  output logic                  d_ready_out,
  output logic                  d_done_out,
  output logic [31:0]           d_rdata_out,
  output logic                  d_err_out,
  output logic                  ram_en_out,
  output logic                  ram_r_nw_out,
  output logic [ADDR_WIDTH-1:0] ram_a_out,
  output logic [7:0]            ram_d_out,
  input  logic [7:0]            ram_d_in
);

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d, n_q, n_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  fetch_q, fetch_d, sext_q, sext_d, mis_q, mis_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  if_done_q, if_done_d, d_done_q, d_done_d;
  logic [31:0]           if_data_q, if_data_d, d_rdata_q, d_rdata_d;

  logic                  take_d, take_if, take_any, req_mis, fin_r, fin_w, fin;
  logic [1:0]            req_size;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  cap_en;
  logic [1:0]            cap_idx;
  logic [31:0]           asm_word;

  always_comb begin
    take_d   = (state_q == IDLE) && d_valid_in;
    take_if  = (state_q == IDLE) && !d_valid_in && if_valid_in;
    take_any = take_d || take_if;
    req_size = take_d ? d_size_in : SZ_W;
    req_addr = take_d ? d_addr_in : if_addr_in;
`ifdef MEM_CTRL_ALIGN_CHK_EN
    req_mis  = is_misaligned(req_size, req_addr[1:0]);
`else
    req_mis  = 1'b0;
`endif
    // READ runs one extra cycle to catch the last byte from the registered RAM.
    fin_r = (state_q == READ) && (cnt_q == n_q);
    fin_w = (state_q == WRITE) && (mis_q || (cnt_q == n_q - 3'd1));
    fin   = fin_r || fin_w;
  end

  // A misaligned request parks one cycle in WRITE with the RAM gated off.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take_any) state_d = (req_mis || (take_d && d_we_in)) ? WRITE : READ;
      READ:    if (fin_r) state_d = IDLE;
      WRITE:   if (fin_w) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    d_ready_out  = (state_q == IDLE);
    if_ready_out = (state_q == IDLE) && !d_valid_in;
    ram_en_out   = 1'b0;
    ram_r_nw_out = 1'b1;
    ram_a_out    = '0;
    ram_d_out    = '0;
    case (state_q)
      READ: begin
        if (cnt_q < n_q) begin
          ram_en_out = 1'b1;
          ram_a_out  = addr_q + ADDR_WIDTH'(cnt_q);
        end
      end
      WRITE: begin
        if (!mis_q) begin
          ram_en_out   = 1'b1;
          ram_r_nw_out = 1'b0;
          ram_a_out    = addr_q + ADDR_WIDTH'(cnt_q);
          ram_d_out    = 8'(wdata_q >> {cnt_q[1:0], 3'b000});
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    n_d     = n_q;
    addr_d  = addr_q;
    fetch_d = fetch_q;
    sext_d  = sext_q;
    mis_d   = mis_q;
    wdata_d = wdata_q;
    if (take_any) begin
      cnt_d   = '0;
      n_d     = size_to_n(req_size);
      addr_d  = req_addr;
      fetch_d = take_if;
      sext_d  = take_d && d_sext_in;
      mis_d   = req_mis;
      wdata_d = d_wdata_in;
    end else if (state_q != IDLE) begin
      cnt_d = cnt_q + 3'd1;
    end

    cap_en  = (state_q == READ) && (cnt_q != 3'd0);
    cap_idx = 2'(cnt_q - 3'd1);

    if_done_d = fin && fetch_q;
    d_done_d  = fin && !fetch_q;
    if_data_d = if_data_q;
    d_rdata_d = d_rdata_q;
    if (fin && fetch_q) if_data_d = mis_q ? '0 : asm_word;
    if (fin && !fetch_q && (fin_r || mis_q)) d_rdata_d = mis_q ? '0 : asm_word;
  end

  mem_ctrl_byte_asm u_byte_asm (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .clr_in      (take_any),
    .cap_en_in   (cap_en),
    .cap_idx_in  (cap_idx),
    .cap_byte_in (ram_d_in),
    .n_bytes_in  (n_q),
    .sext_in     (sext_q),
    .word_out    (asm_word)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q     <= '0;
      n_q       <= 3'd1;
      addr_q    <= '0;
      fetch_q   <= 1'b0;
      sext_q    <= 1'b0;
      mis_q     <= 1'b0;
      wdata_q   <= '0;
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      if_data_q <= '0;
      d_rdata_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      addr_q    <= addr_d;
      fetch_q   <= fetch_d;
      sext_q    <= sext_d;
      mis_q     <= mis_d;
      wdata_q   <= wdata_d;
      if_done_q <= if_done_d;
      d_done_q  <= d_done_d;
      if_data_q <= if_data_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign if_done_out = if_done_q;
  assign if_data_out = if_data_q;
  assign d_done_out  = d_done_q;
  assign d_rdata_out = d_rdata_q;

`ifdef MEM_CTRL_ALIGN_CHK_EN
  logic d_err_q, d_err_d;

  always_comb d_err_d = fin_w && mis_q && !fetch_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      d_err_q <= 1'b0;
    end else begin
      d_err_q <= d_err_d;
    end
  end

  assign d_err_out = d_err_q;
`else
  assign d_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - randomized self-checking bench for mem_ctrl against a byte-array reference model
module tb_mem_ctrl;

  localparam int AW  = 17;
  localparam int MSZ = 1 << AW;
`ifdef MEM_CTRL_ALIGN_CHK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_valid = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_ready_out, if_done_out;
  logic [31:0]   if_data_out;
  logic          d_valid = 1'b0, d_we = 1'b0, d_sext = 1'b0;
  logic [1:0]    d_size = 2'd0;
  logic [AW-1:0] d_addr = '0;
  logic [31:0]   d_wdata = '0;
  logic          d_ready_out, d_done_out, d_err_out;
  logic [31:0]   d_rdata_out;
  logic          ram_en_out, ram_r_nw_out;
  logic [AW-1:0] ram_a_out;
  logic [7:0]    ram_d_out;
  logic [7:0]    ram_d = 8'h00;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .if_valid_in(if_valid), .if_addr_in(if_addr), .if_ready_out(if_ready_out),
    .if_done_out(if_done_out), .if_data_out(if_data_out),
    .d_valid_in(d_valid), .d_we_in(d_we), .d_size_in(d_size), .d_sext_in(d_sext),
    .d_addr_in(d_addr), .d_wdata_in(d_wdata), .d_ready_out(d_ready_out),
    .d_done_out(d_done_out), .d_rdata_out(d_rdata_out), .d_err_out(d_err_out),
    .ram_en_out(ram_en_out), .ram_r_nw_out(ram_r_nw_out), .ram_a_out(ram_a_out),
    .ram_d_out(ram_d_out), .ram_d_in(ram_d)
  );

  logic [7:0] ram_mem [0:MSZ-1];
  logic [7:0] ref_mem [0:MSZ-1];

  // Registered-read RAM; ram_d carries noise when no read was issued.
  always @(posedge clk) begin
    if (ram_en_out && !ram_r_nw_out) ram_mem[ram_a_out] <= ram_d_out;
    if (ram_en_out && ram_r_nw_out) ram_d <= ram_mem[ram_a_out];
    else ram_d <= 8'($urandom);
  end

  logic [AW-1:0] acc_a [$];
  bit            acc_w [$];
  logic [7:0]    acc_d [$];
  int            if_done_cnt = 0, d_done_cnt = 0;

  always @(negedge clk) begin
    if (ram_en_out) begin
      acc_a.push_back(ram_a_out);
      acc_w.push_back(!ram_r_nw_out);
      acc_d.push_back(ram_d_out);
    end
    if (if_done_out) if_done_cnt++;
    if (d_done_out) d_done_cnt++;
  end

  int n_cmp = 0, n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [AW-1:0] a, input int n, input bit sx);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < n; i++) v |= 32'(ref_mem[(int'(a) + i) % MSZ]) << (8 * i);
    if (sx && n < 4 && v[8*n-1]) v |= ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic run_req(input bit is_f, input bit we_in, input logic [1:0] sz, input bit sx,
                         input logic [AW-1:0] a, input logic [31:0] wd, input string tag,
                         output logic [31:0] rdata);
    int n, exp_lat, lat, ifc0, dc0;
    bit we, mis, acc, done, err;
    logic [31:0] exp;
    we      = is_f ? 1'b0 : we_in;
    n       = is_f ? 4 : (sz == 2'd0 ? 1 : (sz == 2'd1 ? 2 : 4));
    mis     = ALIGN && (n == 4 ? (a[1:0] != 2'd0) : (n == 2 ? a[0] : 1'b0));
    exp_lat = mis ? 1 : (we ? n : n + 1);
    exp     = (we || mis) ? 32'd0 : model_load(a, n, sx && !is_f);
    rdata   = 32'd0;
    err     = 1'b0;
    @(negedge clk);
    if (is_f) begin
      if_valid = 1'b1; if_addr = a;
    end else begin
      d_valid = 1'b1; d_we = we; d_size = sz; d_sext = sx; d_addr = a; d_wdata = wd;
    end
    acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) begin
      #1;
      if (is_f ? if_ready_out : d_ready_out) acc = 1'b1;
      else @(negedge clk);
    end
    if (!acc) begin
      chk({tag, " accept"}, 32'd0, 32'd1);
      if_valid = 1'b0; d_valid = 1'b0;
      return;
    end
    acc_a.delete(); acc_w.delete(); acc_d.delete();
    ifc0 = if_done_cnt; dc0 = d_done_cnt;
    @(negedge clk);
    if_valid = 1'b0; d_valid = 1'b0;
    d_wdata = $urandom; d_addr = AW'($urandom); if_addr = AW'($urandom);
    done = 1'b0; lat = 99;
    for (int c = 1; c <= 20 && !done; c++) begin
      @(negedge clk);
      if (is_f ? if_done_out : d_done_out) begin
        done = 1'b1; lat = c;
        rdata = is_f ? if_data_out : d_rdata_out;
        err = d_err_out;
      end
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    if (!we) chk({tag, " rdata"}, rdata, exp);
    if (!is_f) chk({tag, " err"}, 32'(err), 32'(mis));
    chk({tag, " nacc"}, 32'(acc_a.size()), mis ? 32'd0 : 32'(n));
    for (int i = 0; i < acc_a.size() && i < n; i++) begin
      chk({tag, " addr"}, 32'(acc_a[i]), 32'((int'(a) + i) % MSZ));
      chk({tag, " wr"}, 32'(acc_w[i]), 32'(we));
      if (we) chk({tag, " wbyte"}, 32'(acc_d[i]), 32'(8'(wd >> (8 * i))));
    end
    @(negedge clk); #1;
    chk({tag, " if_done count"}, 32'(if_done_cnt - ifc0), is_f ? 32'd1 : 32'd0);
    chk({tag, " d_done count"}, 32'(d_done_cnt - dc0), is_f ? 32'd0 : 32'd1);
    if (we && !mis)
      for (int i = 0; i < n; i++) ref_mem[(int'(a) + i) % MSZ] = 8'(wd >> (8 * i));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, exp_f;
    int lat, dc0;
    bit d_seen, f_seen;
    bit is_f, we, sx;
    logic [1:0] sz;
    logic [AW-1:0] a;

    for (int i = 0; i < MSZ; i++) begin
      ram_mem[i] = 8'($urandom);
      ref_mem[i] = ram_mem[i];
    end

    repeat (3) @(negedge clk);
    chk("rst ram_en", 32'(ram_en_out), 32'd0);
    chk("rst ram_r_nw", 32'(ram_r_nw_out), 32'd1);
    chk("rst ram_a", 32'(ram_a_out), 32'd0);
    chk("rst ram_d", 32'(ram_d_out), 32'd0);
    chk("rst d_ready", 32'(d_ready_out), 32'd1);
    chk("rst if_ready", 32'(if_ready_out), 32'd1);
    chk("rst dones", {29'd0, if_done_out, d_done_out, d_err_out}, 32'd0);
    chk("rst if_data", if_data_out, 32'd0);
    chk("rst d_rdata", d_rdata_out, 32'd0);
    rst_n = 1'b1;

    // Word fetch with known bytes.
    ram_mem[17'h100] = 8'h11; ram_mem[17'h101] = 8'h22; ram_mem[17'h102] = 8'h33; ram_mem[17'h103] = 8'h44;
    ref_mem[17'h100] = 8'h11; ref_mem[17'h101] = 8'h22; ref_mem[17'h102] = 8'h33; ref_mem[17'h103] = 8'h44;
    run_req(1'b1, 1'b0, 2'd2, 1'b0, 17'h00100, 32'd0, "fetch100", r);
    chk("fetch100 word", r, 32'h44332211);

    // Simultaneous requests: data first, fetch on the next idle edge.
    ram_mem[17'h200] = 8'h80; ref_mem[17'h200] = 8'h80;
    exp_f = model_load(17'h300, 4, 1'b0);
    @(negedge clk);
    d_valid = 1'b1; d_we = 1'b0; d_size = 2'd0; d_sext = 1'b1; d_addr = 17'h200;
    if_valid = 1'b1; if_addr = 17'h300;
    #1;
    chk("prio d_ready", 32'(d_ready_out), 32'd1);
    chk("prio if_ready", 32'(if_ready_out), 32'd0);
    @(negedge clk);
    d_valid = 1'b0;
    d_seen = 1'b0; f_seen = 1'b0;
    for (int c = 1; c <= 30 && !f_seen; c++) begin
      @(negedge clk);
      if (c == 3) if_valid = 1'b0;
      if (d_done_out) begin
        d_seen = 1'b1;
        chk("prio d_lat", 32'(c), 32'd2);
        chk("prio d_rdata", d_rdata_out, 32'hFFFFFF80);
        #1 chk("prio if_ready at done", 32'(if_ready_out), 32'd1);
      end
      if (if_done_out) begin
        f_seen = 1'b1;
        chk("prio if_lat", 32'(c), 32'd8);
        chk("prio if_data", if_data_out, exp_f);
      end
    end
    chk("prio both done", {30'd0, d_seen, f_seen}, 32'd3);
    if_valid = 1'b0;

    // Half store then readback.
    run_req(1'b0, 1'b1, 2'd1, 1'b0, 17'h00010, 32'h1234BEEF, "hstore", r);
    run_req(1'b0, 1'b0, 2'd1, 1'b0, 17'h00010, 32'd0, "hload", r);
    chk("hload const", r, 32'h0000BEEF);

    // Address wrap at top of memory.
    run_req(1'b0, 1'b0, 2'd2, 1'b0, 17'h1FFFE, 32'd0, "wrap", r);

    // Misaligned word load: error pulse with the check, bytewise access without.
    run_req(1'b0, 1'b0, 2'd2, 1'b1, 17'h00002, 32'd0, "misw", r);

    // Reset during cycle E+2 of a word load.
    @(negedge clk);
    d_valid = 1'b1; d_we = 1'b0; d_size = 2'd2; d_sext = 1'b0; d_addr = 17'h00040;
    dc0 = d_done_cnt;
    @(negedge clk);
    d_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rstmid en before", 32'(ram_en_out), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid ram_en", 32'(ram_en_out), 32'd0);
    chk("rstmid ram_a", 32'(ram_a_out), 32'd0);
    chk("rstmid d_ready", 32'(d_ready_out), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    chk("rstmid no done", 32'(d_done_cnt - dc0), 32'd0);
    chk("rstmid idle", 32'(d_ready_out), 32'd1);
    run_req(1'b0, 1'b0, 2'd2, 1'b0, 17'h00040, 32'd0, "after rst", r);

    // Randomized mix of fetches, loads and stores.
    for (int k = 0; k < 60; k++) begin
      is_f = ($urandom_range(0, 3) == 0);
      we   = 1'($urandom_range(0, 1));
      sz   = 2'($urandom_range(0, 3));
      sx   = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       a = 17'h1FFFC + AW'($urandom_range(0, 3));
        1, 2:    a = AW'($urandom_range(0, 31));
        default: a = AW'($urandom);
      endcase
      run_req(is_f, we, sz, sx, a, $urandom, $sformatf("rnd%0d", k), r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
